// File: rtl/pwm_generator.sv
// PWM generator with double-buffered period/duty configuration.
// Active values change only while idle or at a period wrap, so a running
// waveform never shows a torn period. A valid/ready handshake loads a shadow
// pair; Pending holds it until the next safe point.
// Optional feature: define PWM_GENERATOR_COMPLEMENT_EN to add PwmOutN, the
// inverted output while running (low while idle or in reset).
module pwm_generator #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             ClkEnable,
  input  logic             Enable,
  input  logic             CfgValid,
  output logic             CfgReady,
  input  logic [WIDTH-1:0] CfgPeriod,
  input  logic [WIDTH-1:0] CfgDuty,
  output logic             PwmOut,
`ifdef PWM_GENERATOR_COMPLEMENT_EN
  output logic             PwmOutN,
`endif
  output logic             PeriodStart
);

  typedef enum logic [0:0] {StIdle, StRun} stateT;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  stateT            state;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] actPeriod;
  logic [WIDTH-1:0] actDuty;
  logic [WIDTH-1:0] shPeriod;
  logic [WIDTH-1:0] shDuty;
  logic             pending;

  logic             accept;
  logic             periodEnd;
  logic             applyShadow;
  logic [WIDTH-1:0] newPeriod;
  logic [WIDTH-1:0] newDuty;
  logic             startLevel;
  logic [WIDTH-1:0] countInc;

  assign CfgReady = !pending;

`ifdef PWM_GENERATOR_COMPLEMENT_EN
  assign PwmOutN = (state == StRun) && !PwmOut;
`endif

  // Decode handshake, period boundary and the active values after this edge
  always_comb begin
    accept      = CfgValid && !pending;
    // A zero period never matches the last count; each tick is treated as a
    // boundary so a pending shadow can still take over.
    periodEnd   = (state == StRun) && Enable && ClkEnable &&
                  ((actPeriod == '0) || (counter == actPeriod - One));
    applyShadow = pending && ((state == StIdle) || periodEnd);
    newPeriod   = applyShadow ? shPeriod : actPeriod;
    newDuty     = applyShadow ? shDuty : actDuty;
    // Level at count 0 under the post-edge values; a zero period forces low
    startLevel  = (newPeriod != '0) && (newDuty != '0);
    countInc    = counter + One;
  end

  // Run/idle FSM, counter, configuration registers and registered outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= StIdle;
      counter     <= '0;
      actPeriod   <= '0;
      actDuty     <= '0;
      shPeriod    <= '0;
      shDuty      <= '0;
      pending     <= 1'b0;
      PwmOut      <= 1'b0;
      PeriodStart <= 1'b0;
    end else begin
      // accept and applyShadow are exclusive: one needs pending low, the other high
      if (accept) begin
        shPeriod <= CfgPeriod;
        shDuty   <= CfgDuty;
        pending  <= 1'b1;
      end else if (applyShadow) begin
        actPeriod <= shPeriod;
        actDuty   <= shDuty;
        pending   <= 1'b0;
      end

      PeriodStart <= 1'b0;

      unique case (state)
        StIdle: begin
          counter <= '0;
          PwmOut  <= 1'b0;
          if (Enable) begin
            state       <= StRun;
            PeriodStart <= (newPeriod != '0);
            PwmOut      <= startLevel;
          end
        end
        StRun: begin
          if (!Enable) begin
            state   <= StIdle;
            counter <= '0;
            PwmOut  <= 1'b0;
          end else if (ClkEnable) begin
            if (periodEnd) begin
              counter     <= '0;
              PeriodStart <= (newPeriod != '0);
              PwmOut      <= startLevel;
            end else begin
              counter <= countInc;
              PwmOut  <= (countInc < actDuty);
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: directed waveform checks with literal expectations
// plus a randomized run compared every cycle against a period/position model.
module tb_pwm_generator;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       ClkEnable;
  logic       Enable;
  logic       CfgValid;
  logic       CfgReady;
  logic [7:0] CfgPeriod;
  logic [7:0] CfgDuty;
  logic       PwmOut;
  logic       PeriodStart;
`ifdef PWM_GENERATOR_COMPLEMENT_EN
  logic       PwmOutN;
`endif

  pwm_generator #(.WIDTH(8)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .ClkEnable  (ClkEnable),
    .Enable     (Enable),
    .CfgValid   (CfgValid),
    .CfgReady   (CfgReady),
    .CfgPeriod  (CfgPeriod),
    .CfgDuty    (CfgDuty),
    .PwmOut     (PwmOut),
`ifdef PWM_GENERATOR_COMPLEMENT_EN
    .PwmOutN    (PwmOutN),
`endif
    .PeriodStart(PeriodStart)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Model state: running flag, position inside the period, active/shadow config
  bit mRun, mPend, mPs;
  int mPos, mPer, mDuty, mShPer, mShDuty;
  bit expPwm;

  logic [15:0] pwmBits, psBits, rdyBits, nBits;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelApply();
    mPer  = mShPer;
    mDuty = mShDuty;
    mPend = 1'b0;
  endtask

  task automatic modelEdge();
    bit acc, started;
    if (!Rst_n) begin
      mRun = 0; mPend = 0; mPs = 0;
      mPos = 0; mPer = 0; mDuty = 0; mShPer = 0; mShDuty = 0;
      return;
    end
    acc     = CfgValid && !mPend;
    started = 1'b0;
    if (!mRun) begin
      if (mPend) modelApply();
      mPos = 0;
      if (Enable) begin
        mRun    = 1'b1;
        started = 1'b1;
      end
    end else if (!Enable) begin
      mRun = 1'b0;
      mPos = 0;
    end else if (ClkEnable) begin
      if (mPer == 0 || mPos == mPer - 1) begin
        if (mPend) modelApply();
        mPos    = 0;
        started = 1'b1;
      end else begin
        mPos++;
      end
    end
    mPs = started && (mPer != 0);
    if (acc) begin
      mShPer  = int'(CfgPeriod);
      mShDuty = int'(CfgDuty);
      mPend   = 1'b1;
    end
  endtask

  // Model advances on the same events as the DUT
  initial forever begin
    @(posedge Clk or negedge Rst_n);
    modelEdge();
  end

  // Compare DUT against model on every falling edge
  initial forever begin
    @(negedge Clk);
    if (checkEn) begin
      expPwm = mRun && (mPer != 0) && (mPos < mDuty);
      chk("model_PwmOut", {15'b0, PwmOut}, {15'b0, expPwm});
      chk("model_PeriodStart", {15'b0, PeriodStart}, {15'b0, mPs});
      chk("model_CfgReady", {15'b0, CfgReady}, {15'b0, !mPend});
`ifdef PWM_GENERATOR_COMPLEMENT_EN
      chk("model_PwmOutN", {15'b0, PwmOutN}, {15'b0, mRun && !expPwm});
`endif
    end
  end

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      pwmBits = {pwmBits[14:0], PwmOut};
      psBits  = {psBits[14:0], PeriodStart};
      rdyBits = {rdyBits[14:0], CfgReady};
`ifdef PWM_GENERATOR_COMPLEMENT_EN
      nBits   = {nBits[14:0], PwmOutN};
`endif
    end
  endtask

  task automatic clearBits();
    pwmBits = '0; psBits = '0; rdyBits = '0; nBits = '0;
  endtask

  // Drop to idle, load a configuration and let it copy into the active pair
  task automatic cfgIdle(input logic [7:0] p, input logic [7:0] d);
    Enable = 1'b0;
    run(2);
    CfgPeriod = p;
    CfgDuty   = d;
    CfgValid  = 1'b1;
    run(1);
    CfgValid  = 1'b0;
    run(1);
  endtask

  task automatic asyncReset();
    #2 Rst_n = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  initial begin
    Rst_n = 1'b0; ClkEnable = 1'b0; Enable = 1'b0; CfgValid = 1'b0;
    CfgPeriod = '0; CfgDuty = '0;
    clearBits();
    repeat (2) @(negedge Clk);
    checkEn = 1'b1;
    Rst_n   = 1'b1;
    chk("reset_CfgReady", {15'b0, CfgReady}, 16'd1);
    chk("reset_PwmOut", {15'b0, PwmOut}, 16'd0);
    chk("reset_PeriodStart", {15'b0, PeriodStart}, 16'd0);

    // Period 4 duty 1, tick every cycle
    ClkEnable = 1'b1;
    cfgIdle(8'd4, 8'd1);
    Enable = 1'b1;
    clearBits();
    run(8);
    chk("p4d1_pwm", {8'b0, pwmBits[7:0]}, 16'b1000_1000);
    chk("p4d1_start", {8'b0, psBits[7:0]}, 16'b1000_1000);
`ifdef PWM_GENERATOR_COMPLEMENT_EN
    chk("p4d1_pwmN", {8'b0, nBits[7:0]}, 16'b0111_0111);
`endif
    Enable = 1'b0;
    run(1);
    chk("disable_pwm", {15'b0, PwmOut}, 16'd0);
`ifdef PWM_GENERATOR_COMPLEMENT_EN
    chk("disable_pwmN", {15'b0, PwmOutN}, 16'd0);
`endif

    // Reload mid-period: 4/2 finishes, 5/3 starts at the wrap
    cfgIdle(8'd4, 8'd2);
    Enable = 1'b1;
    run(2);
    clearBits();
    CfgPeriod = 8'd5; CfgDuty = 8'd3; CfgValid = 1'b1;
    run(1);
    CfgValid = 1'b0;
    run(7);
    chk("reload_pwm", {8'b0, pwmBits[7:0]}, 16'b0011_1001);
    chk("reload_start", {8'b0, psBits[7:0]}, 16'b0010_0001);
    chk("reload_ready", {8'b0, rdyBits[7:0]}, 16'b0011_1111);

    // Boundary configurations
    cfgIdle(8'd4, 8'd10);
    Enable = 1'b1; clearBits(); run(8);
    chk("duty_over_pwm", {8'b0, pwmBits[7:0]}, 16'h00ff);
    chk("duty_over_start", {8'b0, psBits[7:0]}, 16'b1000_1000);
    cfgIdle(8'd4, 8'd0);
    Enable = 1'b1; clearBits(); run(8);
    chk("duty0_pwm", {8'b0, pwmBits[7:0]}, 16'h0000);
    cfgIdle(8'd0, 8'd5);
    Enable = 1'b1; clearBits(); run(8);
    chk("period0_pwm", {8'b0, pwmBits[7:0]}, 16'h0000);
    chk("period0_start", {8'b0, psBits[7:0]}, 16'h0000);

    // Tick every third cycle, period 2 duty 1
    cfgIdle(8'd2, 8'd1);
    Enable = 1'b1;
    clearBits();
    for (int i = 0; i < 12; i++) begin
      ClkEnable = (i % 3 == 2);
      run(1);
    end
    chk("slow_tick_pwm", {4'b0, pwmBits[11:0]}, 16'b1100_0111_0001);
    chk("slow_tick_start", {4'b0, psBits[11:0]}, 16'b1000_0100_0001);

    // Reset mid-period with a pending configuration
    ClkEnable = 1'b1;
    cfgIdle(8'd4, 8'd2);
    Enable = 1'b1;
    run(1);
    CfgPeriod = 8'd7; CfgDuty = 8'd7; CfgValid = 1'b1;
    run(1);
    CfgValid = 1'b0;
    chk("prereset_ready", {15'b0, CfgReady}, 16'd0);
    chk("prereset_pwm", {15'b0, PwmOut}, 16'd1);
    #2 Rst_n = 1'b0;
    #1;
    chk("inreset_pwm", {15'b0, PwmOut}, 16'd0);
    chk("inreset_start", {15'b0, PeriodStart}, 16'd0);
`ifdef PWM_GENERATOR_COMPLEMENT_EN
    chk("inreset_pwmN", {15'b0, PwmOutN}, 16'd0);
`endif
    @(negedge Clk);
    Rst_n = 1'b1;
    chk("postreset_ready", {15'b0, CfgReady}, 16'd1);
    clearBits();
    run(6);
    chk("lost_cfg_pwm", {10'b0, pwmBits[5:0]}, 16'h0000);
    chk("lost_cfg_start", {10'b0, psBits[5:0]}, 16'h0000);
    chk("lost_cfg_ready", {10'b0, rdyBits[5:0]}, 16'h003f);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      Enable    = ($urandom_range(0, 19) != 0);
      ClkEnable = ($urandom_range(0, 2) != 0);
      CfgValid  = ($urandom_range(0, 4) == 0);
      CfgPeriod = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      CfgDuty   = 8'($urandom_range(0, 9));
      if ($urandom_range(0, 499) == 0) asyncReset();
      else run(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
